// File: rtl/axilite_uart_tx_master.sv
`default_nettype none
// ============================================================================
// Module      : axilite_uart_tx_master
// Description : Byte-stream to AXI4-Lite bridge feeding a UART-lite transmit
//               FIFO. Each accepted byte is sent as follows. The status
//               register (BASE+0x8) is polled until the TX FIFO is not full
//               (rdata[3] == 0). The byte is then written to the TX FIFO
//               register (BASE+0x4). Only one AXI transaction is ever in
//               flight, and all AXI valid/ready outputs come from flops.
//               Any non-OKAY response sets a sticky error flag. A non-OKAY
//               status read also drops the pending byte.
// Options     : UART_INIT_EN - after reset, write 0x3 to BASE+0xC (TX/RX
//               FIFO reset) before accepting the first byte.
// Ports       : clock_i, reset_ni (async, active-low)
//               byte_i / byte_valid_i / byte_ready_o : byte input stream
//               err_o                                : sticky error flag
//               m_axilite_*                          : AXI4-Lite master
// Revision    : 1.0 - initial release
// ============================================================================
module axilite_uart_tx_master #(
    parameter int                          LOCAL_DATA_WIDTH = 32,
    parameter int                          LOCAL_ADDR_WIDTH = 32,
    parameter logic [LOCAL_ADDR_WIDTH-1:0] UART_BASE_ADDR   = '0
) (
    input  logic                        clock_i,
    input  logic                        reset_ni,
    input  logic [7:0]                  byte_i,
    input  logic                        byte_valid_i,
    output logic                        byte_ready_o,
    output logic                        err_o,
    output logic [LOCAL_ADDR_WIDTH-1:0] m_axilite_awaddr,
    output logic [2:0]                  m_axilite_awprot,
    output logic                        m_axilite_awvalid,
    input  logic                        m_axilite_awready,
    output logic [LOCAL_DATA_WIDTH-1:0] m_axilite_wdata,
    output logic [3:0]                  m_axilite_wstrb,
    output logic                        m_axilite_wvalid,
    input  logic                        m_axilite_wready,
    input  logic [1:0]                  m_axilite_bresp,
    input  logic                        m_axilite_bvalid,
    output logic                        m_axilite_bready,
    output logic [LOCAL_ADDR_WIDTH-1:0] m_axilite_araddr,
    output logic [2:0]                  m_axilite_arprot,
    output logic                        m_axilite_arvalid,
    input  logic                        m_axilite_arready,
    input  logic [LOCAL_DATA_WIDTH-1:0] m_axilite_rdata,
    input  logic [1:0]                  m_axilite_rresp,
    input  logic                        m_axilite_rvalid,
    output logic                        m_axilite_rready
);

    localparam logic [1:0] c_resp_okay = 2'b00;

    localparam logic [LOCAL_ADDR_WIDTH-1:0] c_tx_addr   = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(4);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] c_stat_addr = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(8);
`ifdef UART_INIT_EN
    localparam logic [LOCAL_ADDR_WIDTH-1:0] c_ctrl_addr = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(12);
    localparam logic [LOCAL_DATA_WIDTH-1:0] c_fifo_rst  = LOCAL_DATA_WIDTH'(3);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STAT_AR  = 3'd1,
        ST_STAT_R   = 3'd2,
        ST_WR_AWW   = 3'd3,
        ST_WR_B     = 3'd4
`ifdef UART_INIT_EN
        ,
        ST_INIT     = 3'd5,
        ST_INIT_AWW = 3'd6,
        ST_INIT_B   = 3'd7
`endif
    } state_t;

`ifdef UART_INIT_EN
    localparam state_t c_reset_state = ST_INIT;
`else
    localparam state_t c_reset_state = ST_IDLE;
`endif

    state_t                      r_state, w_state_nxt;
    logic [7:0]                  r_byte, w_byte_nxt;
    logic                        r_byte_ready, w_byte_ready_nxt;
    logic                        r_err, w_err_nxt;
    logic                        r_arvalid, w_arvalid_nxt;
    logic                        r_rready, w_rready_nxt;
    logic                        r_awvalid, w_awvalid_nxt;
    logic                        r_wvalid, w_wvalid_nxt;
    logic                        r_bready, w_bready_nxt;
    logic [LOCAL_ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
    logic [LOCAL_ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
    logic [LOCAL_DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;

    // A write channel counts as done once its valid is down or being
    // accepted this cycle; AW and W may complete in either order.
    logic w_aw_done, w_w_done, w_bad_bresp;
    assign w_aw_done   = ~r_awvalid | m_axilite_awready;
    assign w_w_done    = ~r_wvalid  | m_axilite_wready;
    assign w_bad_bresp = (m_axilite_bresp != c_resp_okay);

    // Only the TX-full bit of the status word is of interest.
    logic w_unused_rdata;
    assign w_unused_rdata = ^{m_axilite_rdata[LOCAL_DATA_WIDTH-1:4], m_axilite_rdata[2:0]};

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= c_reset_state;
            r_byte       <= '0;
            r_byte_ready <= 1'b0;
            r_err        <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte       <= w_byte_nxt;
            r_byte_ready <= w_byte_ready_nxt;
            r_err        <= w_err_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_araddr     <= w_araddr_nxt;
            r_awaddr     <= w_awaddr_nxt;
            r_wdata      <= w_wdata_nxt;
        end
    end

    // Next-state logic also computes next-cycle values of every registered
    // output, so each handshake is answered on the following cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_nxt       = r_byte;
        w_byte_ready_nxt = r_byte_ready;
        w_err_nxt        = r_err;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_awvalid_nxt    = r_awvalid;
        w_wvalid_nxt     = r_wvalid;
        w_bready_nxt     = r_bready;
        w_araddr_nxt     = r_araddr;
        w_awaddr_nxt     = r_awaddr;
        w_wdata_nxt      = r_wdata;

        case (r_state)
            ST_IDLE: begin
                // byte_ready_o comes back by itself after reset.
                w_byte_ready_nxt = 1'b1;
                if (r_byte_ready && byte_valid_i) begin
                    w_byte_nxt       = byte_i;
                    w_byte_ready_nxt = 1'b0;
                    w_arvalid_nxt    = 1'b1;
                    w_araddr_nxt     = c_stat_addr;
                    w_state_nxt      = ST_STAT_AR;
                end
            end
            ST_STAT_AR: begin
                if (m_axilite_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_STAT_R;
                end
            end
            ST_STAT_R: begin
                if (m_axilite_rvalid) begin
                    w_rready_nxt = 1'b0;
                    if (m_axilite_rresp != c_resp_okay) begin
                        w_err_nxt        = 1'b1;
                        w_byte_nxt       = '0;
                        w_byte_ready_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else if (m_axilite_rdata[3]) begin
                        // TX FIFO full: poll the status register again.
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_STAT_AR;
                    end else begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_awaddr_nxt  = c_tx_addr;
                        w_wdata_nxt   = {{(LOCAL_DATA_WIDTH-8){1'b0}}, r_byte};
                        w_state_nxt   = ST_WR_AWW;
                    end
                end
            end
            ST_WR_AWW: begin
                if (m_axilite_awready) w_awvalid_nxt = 1'b0;
                if (m_axilite_wready)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (m_axilite_bvalid) begin
                    w_bready_nxt     = 1'b0;
                    w_byte_ready_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                    if (w_bad_bresp) w_err_nxt = 1'b1;
                end
            end
`ifdef UART_INIT_EN
            ST_INIT: begin
                w_awvalid_nxt = 1'b1;
                w_wvalid_nxt  = 1'b1;
                w_awaddr_nxt  = c_ctrl_addr;
                w_wdata_nxt   = c_fifo_rst;
                w_state_nxt   = ST_INIT_AWW;
            end
            ST_INIT_AWW: begin
                if (m_axilite_awready) w_awvalid_nxt = 1'b0;
                if (m_axilite_wready)  w_wvalid_nxt  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_INIT_B;
                end
            end
            ST_INIT_B: begin
                if (m_axilite_bvalid) begin
                    w_bready_nxt     = 1'b0;
                    w_byte_ready_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                    if (w_bad_bresp) w_err_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = c_reset_state;
            end
        endcase
    end

    assign byte_ready_o      = r_byte_ready;
    assign err_o             = r_err;
    assign m_axilite_araddr  = r_araddr;
    assign m_axilite_arprot  = 3'b000;
    assign m_axilite_arvalid = r_arvalid;
    assign m_axilite_rready  = r_rready;
    assign m_axilite_awaddr  = r_awaddr;
    assign m_axilite_awprot  = 3'b000;
    assign m_axilite_awvalid = r_awvalid;
    assign m_axilite_wdata   = r_wdata;
    assign m_axilite_wstrb   = 4'hF;
    assign m_axilite_wvalid  = r_wvalid;
    assign m_axilite_bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axilite_uart_tx_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axilite_uart_tx_master
// Description : Self-checking bench for axilite_uart_tx_master. An AXI-lite
//               slave model with programmable per-channel delays answers the
//               bridge. Each byte pushes its expected AXI transactions into a
//               scoreboard queue, and a monitor pops and compares them on
//               every observed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axilite_uart_tx_master;

    localparam logic [31:0] BASE = 32'h0;

    logic        clock_i = 1'b0;
    logic        reset_ni;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o, err_o;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clock_i = ~clock_i;

    axilite_uart_tx_master #(
        .LOCAL_DATA_WIDTH(32), .LOCAL_ADDR_WIDTH(32), .UART_BASE_ADDR(BASE)
    ) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .err_o(err_o),
        .m_axilite_awaddr(awaddr), .m_axilite_awprot(awprot),
        .m_axilite_awvalid(awvalid), .m_axilite_awready(awready),
        .m_axilite_wdata(wdata), .m_axilite_wstrb(wstrb),
        .m_axilite_wvalid(wvalid), .m_axilite_wready(wready),
        .m_axilite_bresp(bresp), .m_axilite_bvalid(bvalid), .m_axilite_bready(bready),
        .m_axilite_araddr(araddr), .m_axilite_arprot(arprot),
        .m_axilite_arvalid(arvalid), .m_axilite_arready(arready),
        .m_axilite_rdata(rdata), .m_axilite_rresp(rresp),
        .m_axilite_rvalid(rvalid), .m_axilite_rready(rready)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    exp_t       exp_q[$];
    rsp_t       r_q[$];
    logic [1:0] b_q[$];

    // Slave delays: cycles a valid waits before its ready, or before a
    // response is presented.
    int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;

    int ar_count = 0, wr_count = 0, b_count = 0;
    int last_aw_len = 0, last_w_len = 0;

    // ------------------------------------------------------------------
    // Slave model + monitor. Everything happens on the falling edge. Values
    // seen at one falling edge are the values the DUT sees at the next
    // rising edge, so a handshake happened at that rising edge when both
    // snapshot bits were set.
    // ------------------------------------------------------------------
    always @(negedge clock_i) begin : mon
        bit          p_rst, p_arvalid, p_arready, p_rvalid, p_rready;
        bit          p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        bit          hs_ar, hs_r, hs_aw, hs_w, hs_b;
        int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, aw_run, w_run;
        bit          r_pend, b_pend, aw_got, w_got, init_pending;
        logic [31:0] cap_awaddr, cap_wdata;
        exp_t        e;
        rsp_t        rs;
        if (!reset_ni) begin
            exp_q.delete(); r_q.delete(); b_q.delete();
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            rdata = '0; rresp = '0; bresp = '0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            aw_run = 0; w_run = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            p_rst = 0;
            init_pending = 0;
`ifdef UART_INIT_EN
            e.is_wr = 1; e.addr = BASE + 32'hC; e.data = 32'h3;
            exp_q.push_back(e);
            b_q.push_back(2'b00);
            init_pending = 1;
`endif
        end else begin
            hs_ar = p_rst && p_arvalid && p_arready;
            hs_r  = p_rst && p_rvalid  && p_rready;
            hs_aw = p_rst && p_awvalid && p_awready;
            hs_w  = p_rst && p_wvalid  && p_wready;
            hs_b  = p_rst && p_bvalid  && p_bready;

            if (p_rst && p_arvalid && !p_arready) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, p_araddr);
            end
            if (p_rst && p_awvalid && !p_awready) begin
                check("aw_hold_valid", awvalid, 1);
                check("aw_hold_addr", awaddr, p_awaddr);
            end
            if (p_rst && p_wvalid && !p_wready) begin
                check("w_hold_valid", wvalid, 1);
                check("w_hold_data", wdata, p_wdata);
            end
            check("ar_aw_exclusive", arvalid & (awvalid | wvalid), 0);
            if (init_pending && !hs_b) check("byte_ready_during_init", byte_ready_o, 0);

            // AR channel
            if (hs_ar) begin
                ar_count++;
                if (exp_q.size() == 0) check("unexpected_ar", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("ar_kind_is_write", e.is_wr, 0);
                    check("araddr", p_araddr, e.addr);
                end
                check("arprot", arprot, 0);
                arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
            end else if (arvalid && !arready) begin
                ar_cnt++;
                if (ar_cnt > ar_dly) arready = 1;
            end
            // R channel
            if (hs_r) rvalid = 0;
            if (r_pend) begin
                if (r_cnt >= r_dly) begin
                    if (r_q.size() == 0) begin
                        check("r_q_underflow", 1, 0);
                        rs.resp = 2'b00; rs.data = '0;
                    end else rs = r_q.pop_front();
                    rresp = rs.resp; rdata = rs.data; rvalid = 1; r_pend = 0;
                end else r_cnt++;
            end
            // AW channel
            if (hs_aw) begin
                aw_got = 1; cap_awaddr = p_awaddr;
                awready = 0; aw_cnt = 0; last_aw_len = aw_run; aw_run = 0;
            end else if (awvalid && !awready) begin
                aw_cnt++;
                if (aw_cnt > aw_dly) awready = 1;
            end
            if (awvalid) aw_run++;
            // W channel
            if (hs_w) begin
                w_got = 1; cap_wdata = p_wdata;
                wready = 0; w_cnt = 0; last_w_len = w_run; w_run = 0;
            end else if (wvalid && !wready) begin
                w_cnt++;
                if (w_cnt > w_dly) wready = 1;
            end
            if (wvalid) w_run++;
            // A complete write: compare, then schedule the B response.
            if (aw_got && w_got) begin
                wr_count++;
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("wr_kind_is_write", e.is_wr, 1);
                    check("awaddr", cap_awaddr, e.addr);
                    check("wdata", cap_wdata, e.data);
                end
                check("wstrb", wstrb, 4'hF);
                check("awprot", awprot, 0);
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            // B channel
            if (hs_b) begin
                bvalid = 0; b_count++; init_pending = 0;
            end
            if (b_pend) begin
                if (b_cnt >= b_dly) begin
                    if (b_q.size() == 0) begin
                        check("b_q_underflow", 1, 0);
                        bresp = 2'b00;
                    end else bresp = b_q.pop_front();
                    bvalid = 1; b_pend = 0;
                end else b_cnt++;
            end
            p_rst = 1;
        end
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_rvalid  = rvalid;  p_rready  = rready;
        p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
        p_wvalid  = wvalid;  p_wready  = wready;  p_wdata  = wdata;
        p_bvalid  = bvalid;  p_bready  = bready;
    end

    // ------------------------------------------------------------------
    // Reference model: one byte goes through n_busy status reads that see
    // TX-full and then a final status read. If that read is OKAY, one write
    // of the byte to TX follows. err_o is the OR of every error seen.
    // ------------------------------------------------------------------
    logic err_exp = 1'b0;

    task automatic send_byte(input logic [7:0] b, input int n_busy, input bit rd_err,
                             input bit b_err, output int lat, output logic arv1);
        exp_t e;
        rsp_t rs;
        int   t;
        for (int i = 0; i <= n_busy; i++) begin
            e.is_wr = 0; e.addr = BASE + 32'h8; e.data = '0;
            exp_q.push_back(e);
            if (i < n_busy) begin
                rs.resp = 2'b00; rs.data = $urandom | 32'h8;
            end else if (rd_err) begin
                rs.resp = 2'(2 + $urandom_range(0, 1)); rs.data = $urandom;
            end else begin
                rs.resp = 2'b00; rs.data = $urandom & 32'hFFFF_FFF7;
            end
            r_q.push_back(rs);
        end
        if (!rd_err) begin
            e.is_wr = 1; e.addr = BASE + 32'h4; e.data = {24'h0, b};
            exp_q.push_back(e);
            b_q.push_back(b_err ? 2'b10 : 2'b00);
        end
        @(negedge clock_i);
        byte_i = b; byte_valid_i = 1;
        t = 0;
        while (!byte_ready_o && t < 500) begin
            @(negedge clock_i); t++;
        end
        check("byte_accept_timeout", t >= 500, 0);
        @(negedge clock_i);
        byte_valid_i = 0;
        arv1 = arvalid;
        lat = 1;
        while (!byte_ready_o && lat < 500) begin
            @(negedge clock_i); lat++;
        end
        check("byte_done_timeout", lat >= 500, 0);
        err_exp = err_exp | rd_err | b_err;
        check("err_o", err_o, err_exp);
    endtask

    task automatic set_delays(input int a, input int w, input int x, input int r, input int bd);
        ar_dly = a; aw_dly = w; w_dly = x; r_dly = r; b_dly = bd;
    endtask

    initial begin
        int   lat, a0, w0, b0, t;
        logic arv1;
        exp_t e;
        rsp_t rs;
        reset_ni = 0; byte_i = '0; byte_valid_i = 0;
        repeat (3) @(negedge clock_i);
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_byte_ready", byte_ready_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addrs_data", {araddr, awaddr} | {32'h0, wdata}, 0);
        @(negedge clock_i);
        reset_ni = 1;

        // Zero-wait slave: byte 0x41, byte_ready_o back at cycle 5.
        set_delays(0, 0, 0, 0, 0);
        send_byte(8'h41, 0, 0, 0, lat, arv1);
        check("latency_byte_ready", lat, 5);
        check("arvalid_at_cycle1", arv1, 1);

        // Two busy polls, then a free FIFO: three reads, one write.
        a0 = ar_count; w0 = wr_count;
        send_byte(8'h33, 2, 0, 0, lat, arv1);
        @(negedge clock_i);
        check("busy_ar_count", ar_count - a0, 3);
        check("busy_wr_count", wr_count - w0, 1);

        // AW accepted late, W at once.
        set_delays(0, 3, 0, 0, 0);
        b0 = b_count;
        send_byte(8'hA5, 0, 0, 0, lat, arv1);
        @(negedge clock_i);
        check("awvalid_len", last_aw_len, 4);
        check("wvalid_len", last_w_len, 1);
        check("one_b_accepted", b_count - b0, 1);
        set_delays(0, 0, 0, 0, 0);

        // Write error is sticky; the next byte still goes out.
        send_byte(8'h5A, 0, 0, 1, lat, arv1);
        send_byte(8'h42, 0, 0, 0, lat, arv1);
        // Status-read error drops the byte: no write.
        w0 = wr_count;
        send_byte(8'h77, 1, 1, 0, lat, arv1);
        @(negedge clock_i);
        check("rd_err_no_write", wr_count - w0, 0);

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            send_byte(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0, lat, arv1);
        end

        // Reset while the TX write is stalled.
        set_delays(0, 6, 6, 0, 0);
        e.is_wr = 0; e.addr = BASE + 32'h8; e.data = '0;
        exp_q.push_back(e);
        rs.resp = 2'b00; rs.data = 32'h0;
        r_q.push_back(rs);
        @(negedge clock_i);
        byte_i = 8'hC3; byte_valid_i = 1;
        t = 0;
        while (!byte_ready_o && t < 500) begin
            @(negedge clock_i); t++;
        end
        @(negedge clock_i);
        byte_valid_i = 0;
        t = 0;
        while (!awvalid && t < 50) begin
            @(negedge clock_i); t++;
        end
        check("reached_wr_aww", awvalid, 1);
        #2 reset_ni = 0;
        #1;
        check("async_rst_awvalid", awvalid, 0);
        check("async_rst_wvalid", wvalid, 0);
        check("async_rst_byte_ready", byte_ready_o, 0);
        check("async_rst_err", err_o, 0);
        check("async_rst_awaddr_wdata", {awaddr, wdata}, 0);
        err_exp = 0;
        repeat (2) @(negedge clock_i);
        reset_ni = 1;
        set_delays(0, 0, 0, 0, 0);
        w0 = wr_count; a0 = ar_count;
        repeat (30) @(negedge clock_i);
`ifdef UART_INIT_EN
        check("no_stale_write", wr_count - w0, 1);
`else
        check("no_stale_write", wr_count - w0, 0);
`endif
        check("no_stale_read", ar_count - a0, 0);
        send_byte(8'h99, 0, 0, 0, lat, arv1);
        @(negedge clock_i);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
